// File: rtl/ball_pkg.sv
// ball_pkg: shared types and constants for the ball velocity controller.
//   vel_t        - 2-bit velocity command code understood by the ball module
//   SC_EXT       - PS/2 extended-code prefix byte
//   SC_BREAK     - PS/2 break (key release) prefix byte
//   scan_state_t - prefix-decoder state of the scancode FSM
//   axis_cmd()   - per-axis command selection used on every frame tick
package ball_pkg;

   typedef enum logic [1:0] {
      VEL_DEF  = 2'b00,
      VEL_POS  = 2'b01,
      VEL_NEG  = 2'b10,
      VEL_STOP = 2'b11
   } vel_t;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;

   typedef enum logic [1:0] {
      SC_IDLE,
      SC_E0,
      SC_F0,
      SC_E0F0
   } scan_state_t;

   // Priority: freeze, then held keys (the most recent press wins a tie),
   // then coast on the ball's own velocity. VEL_DEF is never produced.
   function automatic vel_t axis_cmd(input logic       frz,
                                     input logic       pos_held,
                                     input logic       neg_held,
                                     input logic       last_pos,
                                     input logic [1:0] fb);
      vel_t r;
      if (frz)
         r = VEL_STOP;
      else if (pos_held && neg_held)
         r = last_pos ? VEL_POS : VEL_NEG;
      else if (pos_held)
         r = VEL_POS;
      else if (neg_held)
         r = VEL_NEG;
      else if (fb == 2'b01)
         r = VEL_POS;
      else if (fb == 2'b10)
         r = VEL_NEG;
      else
         r = VEL_STOP;
      return r;
   endfunction

endpackage

// File: rtl/ball_velocity_ctrl_ps2_key_event.sv
// ps2_key_event: PS/2 scancode prefix decoder.
//   Clk, Reset          - clock, synchronous active-high reset
//   scan_code/scan_valid - incoming byte and its one-cycle strobe
//   key_evt             - one-cycle strobe, high in the cycle the final byte
//                         of a key sequence arrives
//   key_code            - that final byte
//   key_ext / key_break - sequence carried an E0 / F0 prefix
// The event outputs are combinational from the current state and byte so the
// consumer can update its key state on the same edge that samples scan_valid.
module ps2_key_event
   import ball_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic       key_evt,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break
);

   scan_state_t state_q, state_d;

   always_ff @(posedge Clk) begin
      if (Reset)
         state_q <= SC_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      key_evt   = 1'b0;
      key_code  = scan_code;
      key_ext   = 1'b0;
      key_break = 1'b0;
      if (scan_valid) begin
         case (state_q)
            SC_IDLE: begin
               if (scan_code == SC_EXT)
                  state_d = SC_E0;
               else if (scan_code == SC_BREAK)
                  state_d = SC_F0;
               else
                  key_evt = 1'b1;
            end
            SC_E0: begin
               if (scan_code == SC_BREAK) begin
                  state_d = SC_E0F0;
               end else begin
                  key_evt = 1'b1;
                  key_ext = 1'b1;
                  state_d = SC_IDLE;
               end
            end
            SC_F0: begin
               key_evt   = 1'b1;
               key_break = 1'b1;
               state_d   = SC_IDLE;
            end
            default: begin
               key_evt   = 1'b1;
               key_ext   = 1'b1;
               key_break = 1'b1;
               state_d   = SC_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/ball_velocity_ctrl.sv
// ball_velocity_ctrl: turns arrow/Space key events into per-axis velocity
// commands, re-issued on every frame tick.
//   Clk, Reset                   - clock, synchronous active-high reset
//   scan_code, scan_valid        - PS/2 byte stream from the keyboard interface
//   frame_tick                   - one-cycle pulse per frame
//   velocity_x_fb, velocity_y_fb - velocity codes reported by the ball
//   velocity_x_cmd, velocity_y_cmd - registered commands to the ball
//   frozen                       - freeze mode active (toggled by Space)
module ball_velocity_ctrl
   import ball_pkg::*;
#(
   parameter logic [7:0] KEY_UP    = 8'h75,
   parameter logic [7:0] KEY_DOWN  = 8'h72,
   parameter logic [7:0] KEY_LEFT  = 8'h6B,
   parameter logic [7:0] KEY_RIGHT = 8'h74,
   parameter logic [7:0] KEY_STOP  = 8'h29
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic       frame_tick,
   input  logic [1:0] velocity_x_fb,
   input  logic [1:0] velocity_y_fb,
   output logic [1:0] velocity_x_cmd,
   output logic [1:0] velocity_y_cmd,
   output logic       frozen
);

   logic       key_evt;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;

   ps2_key_event u_key_event (
      .Clk        (Clk),
      .Reset      (Reset),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .key_evt    (key_evt),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_break  (key_break)
   );

   // last_x/last_y: 1 = positive-direction key (right/down) pressed last.
   logic up_q, up_d, dn_q, dn_d, lf_q, lf_d, rt_q, rt_d;
   logic last_x_q, last_x_d, last_y_q, last_y_d;
   logic frozen_q, frozen_d;
   vel_t vel_x_q, vel_x_d, vel_y_q, vel_y_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         lf_q     <= 1'b0;
         rt_q     <= 1'b0;
         last_x_q <= 1'b0;
         last_y_q <= 1'b0;
         frozen_q <= 1'b0;
         vel_x_q  <= VEL_STOP;
         vel_y_q  <= VEL_STOP;
      end else begin
         up_q     <= up_d;
         dn_q     <= dn_d;
         lf_q     <= lf_d;
         rt_q     <= rt_d;
         last_x_q <= last_x_d;
         last_y_q <= last_y_d;
         frozen_q <= frozen_d;
         vel_x_q  <= vel_x_d;
         vel_y_q  <= vel_y_d;
      end
   end

   always_comb begin
      up_d     = up_q;
      dn_d     = dn_q;
      lf_d     = lf_q;
      rt_d     = rt_q;
      last_x_d = last_x_q;
      last_y_d = last_y_q;
      frozen_d = frozen_q;
      vel_x_d  = vel_x_q;
      vel_y_d  = vel_y_q;

      if (key_evt) begin
         if (key_ext) begin
            // Repeat makes re-set an already held bit and refresh last-press.
            if (key_code == KEY_UP) begin
               up_d = !key_break;
               if (!key_break) last_y_d = 1'b0;
            end else if (key_code == KEY_DOWN) begin
               dn_d = !key_break;
               if (!key_break) last_y_d = 1'b1;
            end else if (key_code == KEY_LEFT) begin
               lf_d = !key_break;
               if (!key_break) last_x_d = 1'b0;
            end else if (key_code == KEY_RIGHT) begin
               rt_d = !key_break;
               if (!key_break) last_x_d = 1'b1;
            end
         end else if (!key_break && key_code == KEY_STOP) begin
            frozen_d = !frozen_q;
         end
      end

      // Uses the registered key state, so a byte landing in the tick cycle
      // only affects the following frame.
      if (frame_tick) begin
         vel_x_d = axis_cmd(frozen_q, rt_q, lf_q, last_x_q, velocity_x_fb);
         vel_y_d = axis_cmd(frozen_q, dn_q, up_q, last_y_q, velocity_y_fb);
      end
   end

   assign velocity_x_cmd = vel_x_q;
   assign velocity_y_cmd = vel_y_q;
   assign frozen         = frozen_q;

endmodule

// File: tb/tb_ball_velocity_ctrl.sv
module tb_ball_velocity_ctrl;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] scan_code = 8'h00;
   logic       scan_valid = 1'b0;
   logic       frame_tick = 1'b0;
   logic [1:0] velocity_x_fb = 2'b00;
   logic [1:0] velocity_y_fb = 2'b00;
   logic [1:0] velocity_x_cmd;
   logic [1:0] velocity_y_cmd;
   logic       frozen;

   ball_velocity_ctrl dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .scan_code      (scan_code),
      .scan_valid     (scan_valid),
      .frame_tick     (frame_tick),
      .velocity_x_fb  (velocity_x_fb),
      .velocity_y_fb  (velocity_y_fb),
      .velocity_x_cmd (velocity_x_cmd),
      .velocity_y_cmd (velocity_y_cmd),
      .frozen         (frozen)
   );

   always #5 Clk = ~Clk;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Keys are held if they carry a nonzero press timestamp; the later
   // timestamp wins when both keys of an axis are held.
   int         cyc = 0;
   int         m_t[4];          // 0 up, 1 down, 2 left, 3 right
   logic       m_ext, m_brk, m_frz;
   logic [1:0] m_x, m_y;

   function automatic int key_idx(input logic [7:0] c);
      case (c)
         8'h75:   return 0;
         8'h72:   return 1;
         8'h6B:   return 2;
         8'h74:   return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [1:0] pick(input logic frz, input int neg_t, input int pos_t,
                                       input logic [1:0] fb);
      if (frz) return 2'b11;
      if (pos_t != 0 && pos_t > neg_t) return 2'b01;
      if (neg_t != 0) return 2'b10;
      if (fb == 2'b01 || fb == 2'b10) return fb;
      return 2'b11;
   endfunction

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (Reset) begin
         for (int i = 0; i < 4; i++) m_t[i] <= 0;
         m_ext <= 1'b0;
         m_brk <= 1'b0;
         m_frz <= 1'b0;
         m_x   <= 2'b11;
         m_y   <= 2'b11;
      end else begin
         if (frame_tick) begin
            m_x <= pick(m_frz, m_t[2], m_t[3], velocity_x_fb);
            m_y <= pick(m_frz, m_t[0], m_t[1], velocity_y_fb);
         end
         if (scan_valid) begin
            if (!m_brk && scan_code == 8'hF0) begin
               m_brk <= 1'b1;
            end else if (!m_ext && !m_brk && scan_code == 8'hE0) begin
               m_ext <= 1'b1;
            end else begin
               m_ext <= 1'b0;
               m_brk <= 1'b0;
               if (m_ext) begin
                  if (key_idx(scan_code) >= 0)
                     m_t[key_idx(scan_code)] <= m_brk ? 0 : cyc + 1;
               end else if (!m_brk && scan_code == 8'h29) begin
                  m_frz <= !m_frz;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus the never-00 rule.
   always @(negedge Clk) begin
      if (chk_en) begin
         check("model_x_cmd", velocity_x_cmd, m_x);
         check("model_y_cmd", velocity_y_cmd, m_y);
         check("model_frozen", {1'b0, frozen}, {1'b0, m_frz});
         n_total++;
         if (velocity_x_cmd != 2'b00 && velocity_y_cmd != 2'b00)
            n_pass++;
         else
            $display("FAIL never_00: got x=%b y=%b, expected neither 00", velocity_x_cmd, velocity_y_cmd);
      end
   end

   // ---------------- stimulus (tasks start and end at a negedge) ----------------
   task automatic send(input logic [7:0] b);
      scan_code  = b;
      scan_valid = 1'b1;
      @(negedge Clk);
      scan_valid = 1'b0;
   endtask

   task automatic tick(input logic [1:0] fx, input logic [1:0] fy);
      velocity_x_fb = fx;
      velocity_y_fb = fy;
      frame_tick    = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
   endtask

   task automatic send_tick(input logic [7:0] b, input logic [1:0] fx, input logic [1:0] fy);
      scan_code     = b;
      scan_valid    = 1'b1;
      velocity_x_fb = fx;
      velocity_y_fb = fy;
      frame_tick    = 1'b1;
      @(negedge Clk);
      scan_valid = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [1:0] x, input logic [1:0] y,
                             input logic f);
      $display("txn %s: x=%b y=%b frozen=%b", name, velocity_x_cmd, velocity_y_cmd, frozen);
      check({name, "_x"}, velocity_x_cmd, x);
      check({name, "_y"}, velocity_y_cmd, y);
      check({name, "_frozen"}, {1'b0, frozen}, {1'b0, f});
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      expect_out("reset", 2'b11, 2'b11, 1'b0);
      Reset  = 1'b0;
      chk_en = 1'b1;

      tick(2'b00, 2'b00);
      expect_out("idle_tick", 2'b11, 2'b11, 1'b0);

      send(8'hE0); send(8'h74); tick(2'b00, 2'b00);
      expect_out("right_held", 2'b01, 2'b11, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h74); tick(2'b10, 2'b00);
      expect_out("coast_bounce", 2'b10, 2'b11, 1'b0);

      send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B); tick(2'b00, 2'b00);
      expect_out("both_last_left", 2'b10, 2'b11, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h6B); tick(2'b00, 2'b00);
      expect_out("left_released", 2'b01, 2'b11, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h74);

      send(8'hE0); send(8'h72); tick(2'b00, 2'b00);
      expect_out("down_held", 2'b11, 2'b01, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h72);

      send(8'h29); tick(2'b00, 2'b00);
      expect_out("freeze_on", 2'b11, 2'b11, 1'b1);
      send(8'h29); tick(2'b01, 2'b10);
      expect_out("freeze_off", 2'b01, 2'b10, 1'b0);

      send_tick(8'hE0, 2'b01, 2'b10);
      expect_out("byte_with_tick", 2'b01, 2'b10, 1'b0);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      expect_out("mid_seq_reset", 2'b11, 2'b11, 1'b0);
      send(8'h75); tick(2'b00, 2'b00);
      expect_out("75_non_ext", 2'b11, 2'b11, 1'b0);

      send(8'hE0); send_tick(8'h1C, 2'b00, 2'b00);
      expect_out("unknown_ext", 2'b11, 2'b11, 1'b0);
      send(8'hE0); send(8'h75); tick(2'b00, 2'b00);
      expect_out("up_after_unknown", 2'b11, 2'b10, 1'b0);

      // Key byte and tick in the same cycle: this tick must still see "no key".
      send(8'hE0); send_tick(8'h6B, 2'b00, 2'b00);
      expect_out("tick_sees_old_keys", 2'b11, 2'b10, 1'b0);
      tick(2'b00, 2'b00);
      expect_out("next_tick_left", 2'b10, 2'b10, 1'b0);

      repeat (2) @(negedge Clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1);
   end

endmodule
